// File: rtl/fifo_flow_ctrl_param.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, registered read-valid strobe and sticky overflow/underflow errors.
module fifo_flow_ctrl_param #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int THR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enable,
  input  logic [THR_WIDTH-1:0]  umbral_af,
  input  logic [THR_WIDTH-1:0]  umbral_ae,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  pause,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  // Threshold arithmetic is one bit wider than its widest operand so count + umbral_af never wraps.
  localparam int SW    = ((THR_WIDTH > CW) ? THR_WIDTH : CW) + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [CW-1:0]         count;
  logic                  pop_ok;
  logic                  push_ok;
  logic [SW-1:0]         af_sum;

  assign fifo_count = count;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign pop_ok     = rd_enable & ~empty;
  assign push_ok    = wr_enable & (~full | pop_ok);

  assign af_sum       = SW'(count) + SW'(umbral_af);
  assign almost_full  = ~full & (af_sum >= SW'(DEPTH));
  assign almost_empty = ~empty & (SW'(count) <= SW'(umbral_ae));
  assign pause        = almost_full | full;

  // NOTE: storage arrays carry no reset; their contents are only observable through pointers that are reset.
  always_ff @(posedge clk) begin
    if (push_ok && init && !reset) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (!init) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (pop_ok) begin
        data_out  <= mem[rd_ptr];
        valid_out <= 1'b1;
        rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
      end else begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end

      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end

      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (wr_enable && !push_ok) begin
        overflow_err <= 1'b1;
      end
      if (rd_enable && empty) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_flow_ctrl_param.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fifo_flow_ctrl_param;

  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int TW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic          wr_enable;
  logic [DW-1:0] data_in;
  logic          rd_enable;
  logic [TW-1:0] umbral_af;
  logic [TW-1:0] umbral_ae;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   fifo_count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          pause;
  logic          overflow_err;
  logic          underflow_err;

  fifo_flow_ctrl_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .THR_WIDTH(TW)) dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .wr_enable     (wr_enable),
    .data_in       (data_in),
    .rd_enable     (rd_enable),
    .umbral_af     (umbral_af),
    .umbral_ae     (umbral_ae),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .fifo_count    (fifo_count),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .pause         (pause),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered queue of stored words plus the registered outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovf;
  logic          m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    int  cnt;
    int  af_thr;
    int  ae_thr;
    cnt    = q.size();
    af_thr = int'(umbral_af);
    ae_thr = int'(umbral_ae);
    check({tag, ".count"}, 32'(fifo_count), 32'(cnt));
    check({tag, ".full"},  32'(full),  32'(cnt == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    check({tag, ".af"},    32'(almost_full),  32'((cnt < DEPTH) && (cnt + af_thr >= DEPTH)));
    check({tag, ".ae"},    32'(almost_empty), 32'((cnt > 0) && (cnt <= ae_thr)));
    check({tag, ".pause"}, 32'(pause), 32'((cnt == DEPTH) || (cnt + af_thr >= DEPTH)));
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".dout"},  32'(data_out),      32'(m_dout));
    check({tag, ".valid"}, 32'(valid_out),     32'(m_valid));
    check({tag, ".ovf"},   32'(overflow_err),  32'(m_ovf));
    check({tag, ".udf"},   32'(underflow_err), 32'(m_udf));
    check_flags(tag);
  endtask

  // One clock: drive at negedge, check combinational flags, advance model at posedge, check after.
  task automatic step(input string tag, input logic wr, input logic [DW-1:0] d,
                      input logic rd, input logic ini);
    logic pop;
    logic push;
    @(negedge clk);
    wr_enable = wr;
    data_in   = d;
    rd_enable = rd;
    init      = ini;
    #1 check_flags({tag, ".pre"});
    @(posedge clk);
    if (!ini) begin
      model_clear();
    end else begin
      pop  = rd && (q.size() > 0);
      push = wr && ((q.size() < DEPTH) || pop);
      if (rd && q.size() == 0) m_udf = 1'b1;
      if (wr && !push)         m_ovf = 1'b1;
      if (pop) begin
        m_dout  = q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_dout  = '0;
        m_valid = 1'b0;
      end
      if (push) q.push_back(d);
    end
    #1 check_regs({tag, ".post"});
  endtask

  initial begin
    reset     = 1'b1;
    init      = 1'b1;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    data_in   = '0;
    umbral_af = 4'd1;
    umbral_ae = 4'd1;
    model_clear();
    #12 check_regs("reset");
    @(negedge clk);
    reset = 1'b0;

    // 1: fill 01..04
    for (int i = 1; i <= 4; i++) step("fill", 1'b1, DW'(i), 1'b0, 1'b1);
    // 2: overflow at full, then drain
    step("ovf", 1'b1, 6'h3F, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("drain1", 1'b0, '0, 1'b1, 1'b1);
    // 3: simultaneous push+pop at full
    for (int i = 1; i <= 4; i++) step("refill", 1'b1, DW'(i), 1'b0, 1'b1);
    step("pushpop_full", 1'b1, 6'h2A, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step("drain2", 1'b0, '0, 1'b1, 1'b1);
    // 4: underflow, then push+pop while empty
    step("udf", 1'b0, '0, 1'b1, 1'b1);
    step("pushpop_empty", 1'b1, 6'h05, 1'b1, 1'b1);
    step("drain3", 1'b0, '0, 1'b1, 1'b1);
    // 5: interleaved across pointer wrap
    for (int i = 0; i < 12; i++) begin
      step("wrap_push", 1'b1, DW'(i), 1'b0, 1'b1);
      step("wrap_pop",  1'b0, '0,     1'b1, 1'b1);
    end
    // 6a: asynchronous reset at count 3, with sticky errors set
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, DW'(i + 7), 1'b0, 1'b1);
    step("pre_rst_pop", 1'b0, '0, 1'b1, 1'b1);
    step("pre_rst_push", 1'b1, 6'h10, 1'b0, 1'b1);
    @(negedge clk);
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    #2 reset = 1'b1;
    #1 model_clear();
    check_regs("async_rst");
    #1 reset = 1'b0;
    // 6b: synchronous init clear at count 2, push ignored
    step("udf2", 1'b0, '0, 1'b1, 1'b1);
    step("pre_init", 1'b1, 6'h21, 1'b0, 1'b1);
    step("pre_init", 1'b1, 6'h22, 1'b0, 1'b1);
    step("init_clr", 1'b1, 6'h11, 1'b0, 1'b0);
    step("post_init", 1'b1, 6'h12, 1'b0, 1'b1);
    step("post_init", 1'b0, '0, 1'b1, 1'b1);

    // Randomized traffic with moving thresholds and occasional soft clears
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        umbral_af = TW'($urandom_range(0, 15));
        umbral_ae = TW'($urandom_range(0, 15));
      end
      step("rand", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 49) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
